// File: rtl/prior_pkg.sv
// Shared definitions for the prior_encoder_rr block.
//   MODE_FIXED : fixed priority, highest set index wins
//   MODE_RR    : round-robin, downward search from the rotating pointer
package prior_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : prior_pkg

// File: rtl/prior_sel.sv
// Combinational grant selector for prior_encoder_rr.
// Ports:
//   cand       - candidate request vector (N bits)
//   ptr        - round-robin start index (searched first, downward)
//   mode       - MODE_FIXED or MODE_RR
//   sel_idx    - selected index (0 when cand is empty)
//   sel_onehot - one-hot form of sel_idx (all zero when cand is empty)
module prior_sel
    import prior_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] sel_idx,
    output logic [N-1:0] sel_onehot
);

    localparam int unsigned DN = 2 * N;

    logic [DN-1:0] dbl;
    logic [W-1:0]  start;
    int unsigned   lim;
    int unsigned   hit;
    logic          found;

    // Duplicating cand and keeping only positions <= start+N turns the
    // wrapping downward search into a plain highest-set-bit search: the upper
    // copy covers start..0, the lower copy covers N-1..0 after the wrap.
    // Fixed priority is the same search started from N-1.
    always_comb begin
        start = (mode == MODE_RR) ? ptr : W'(N - 1);
        lim   = N + 32'(start);
        dbl   = {cand, cand};
        hit   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < DN; i++) begin
            if (dbl[i] && (i <= lim)) begin
                hit   = i;
                found = 1'b1;
            end
        end
        sel_idx    = found ? W'(hit % N) : '0;
        sel_onehot = found ? (N'(1) << sel_idx) : '0;
    end

endmodule : prior_sel

// File: rtl/prior_encoder_rr.sv
// Sticky-request priority encoder with fixed or round-robin policy and a
// single valid/ready output slot.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   req         - N request bits, latched into pending until granted
//   mode        - MODE_FIXED (highest index) or MODE_RR (rotating)
//   out_ready   - consumer accepts the presented grant
//   out_valid   - out_idx holds a granted channel
//   out_idx     - granted channel index
//   pending_any - OR of the registered pending vector
module prior_encoder_rr
    import prior_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         pending_any
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         pending_any_q;

    logic [N-1:0] cand;
    logic         load;
    logic         grant;
    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_onehot;

    // New requests are grantable in the cycle they arrive.
    assign cand  = pending_q | req;
    assign load  = !out_valid_q || out_ready;
    assign grant = load && (|cand);

    prior_sel #(
        .N (N),
        .W (W)
    ) u_sel (
        .cand       (cand),
        .ptr        (ptr_q),
        .mode       (mode),
        .sel_idx    (sel_idx),
        .sel_onehot (sel_onehot)
    );

    // Next-state: slot reloads when free or accepted; a grant clears its own
    // bit, including a same-cycle req on that bit.
    always_comb begin
        pending_d   = cand;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = grant;
        end
        if (grant) begin
            out_idx_d = sel_idx;
            pending_d = cand & ~sel_onehot;
            if (mode == MODE_RR) begin
                ptr_d = (sel_idx == '0) ? W'(N - 1) : sel_idx - W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            ptr_q         <= W'(N - 1);
            out_valid_q   <= 1'b0;
            out_idx_q     <= '0;
            pending_any_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            pending_any_q <= |pending_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pending_any = pending_any_q;

endmodule : prior_encoder_rr

// File: tb/tb_prior_encoder_rr.sv
// Self-checking bench for prior_encoder_rr (N=8): directed table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_prior_encoder_rr;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 3;
    localparam int          NI = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         pending_any;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference state
    logic [7:0] m_pend;
    logic       m_ov;
    int         m_idx;
    int         m_ptr;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic       rdy;
        logic [7:0] req;
        logic       ev;
        logic [2:0] ei;
        logic       ep;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    prior_encoder_rr #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mode        (mode),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .pending_any (pending_any)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model of one rising edge using the currently driven inputs.
    task automatic model_step();
        logic [7:0] c;
        int         k;
        if (!rst_n) begin
            m_pend = '0;
            m_ov   = 1'b0;
            m_idx  = 0;
            m_ptr  = NI - 1;
        end else begin
            c = m_pend | req;
            if (!m_ov || out_ready) begin
                if (c == 8'h00) begin
                    m_ov = 1'b0;
                end else begin
                    k = -1;
                    if (mode == 1'b0) begin
                        for (int j = NI - 1; j >= 0; j--)
                            if (k < 0 && c[j]) k = j;
                    end else begin
                        for (int s = 0; s < NI; s++) begin
                            int j;
                            j = (m_ptr - s + NI) % NI;
                            if (k < 0 && c[j]) k = j;
                        end
                    end
                    m_ov  = 1'b1;
                    m_idx = k;
                    c[k]  = 1'b0;
                    if (mode == 1'b1) m_ptr = (k + NI - 1) % NI;
                end
            end
            m_pend = c;
        end
    endtask

    task automatic tick(input logic r, input logic m, input logic rd, input logic [7:0] q);
        rst_n     = r;
        mode      = m;
        out_ready = rd;
        req       = q;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic md;
        logic rr, rdy;
        logic [7:0] q;

        rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; req = '0;

        //          rst   mode  rdy   req    ev    ei    ep
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h45, 1'b1, 3'd6, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 3'd2, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 3'd5, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 3'd5, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 3'd7, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 3'd4, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 3'd4, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].rst_n, tbl[i].mode, tbl[i].rdy, tbl[i].req);
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d out_idx", i), 32'(out_idx), 32'(tbl[i].ei));
            chk($sformatf("tbl%0d pending_any", i), 32'(pending_any), 32'(tbl[i].ep));
        end

        // Round-robin with all requests held: first grant equals fixed priority.
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, 1'b1, 1'b1, 8'hFF);
            chk($sformatf("rr_sweep%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("rr_sweep%0d idx", c), 32'(out_idx), 32'((7 - c + 16) % 8));
        end

        // Pending bit 3 granted while req[3] arrives again: one grant only.
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        tick(1'b1, 1'b0, 1'b1, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 8'h08);
        chk("collide stall pending_any", 32'(pending_any), 32'd1);
        tick(1'b1, 1'b0, 1'b1, 8'h08);
        chk("collide grant idx", 32'(out_idx), 32'd3);
        chk("collide pending_any", 32'(pending_any), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 8'h00);
        chk("collide no regrant", 32'(out_valid), 32'd0);

        // Round-robin resumes below the last grant, then wraps.
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        tick(1'b1, 1'b1, 1'b1, 8'h04);
        chk("rr_ptr grant2", 32'(out_idx), 32'd2);
        tick(1'b1, 1'b1, 1'b0, 8'h42);
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        chk("rr_ptr grant1", 32'(out_idx), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        chk("rr_ptr grant6", 32'(out_idx), 32'd6);
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        chk("rr_ptr drained", 32'(out_valid), 32'd0);

        // Random stimulus against the model.
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        md = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rr  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) md = ~md;
            rdy = ($urandom_range(0, 3) != 0);
            q   = 8'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) q = 8'hFF;
            tick(rr, md, rdy, q);
            chk($sformatf("rand%0d out_valid", c), 32'(out_valid), 32'(m_ov));
            chk($sformatf("rand%0d out_idx", c), 32'(out_idx), 32'(m_idx));
            chk($sformatf("rand%0d pending_any", c), 32'(pending_any), 32'(|m_pend));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_prior_encoder_rr

// File: doc/prior_encoder_rr.md
PRIOR_ENCODER_RR -- requirements
Module: prior_encoder_rr

Interface
REQ-001 The parameter N SHALL default to 8 and set the number of request inputs (legal range 2..64).
REQ-002 The parameter W SHALL default to $clog2(N) and set the index width; it is not overridden independently.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and be the reset: synchronous and active-low.
REQ-005 The port req SHALL be an input, N bits wide; a bit set to 1 is a one-cycle request pulse or a level on channel i.
REQ-006 The port mode SHALL be an input, 1 bit wide, selecting the policy: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 The port out_ready SHALL be an input, 1 bit wide, and be the consumer accept signal.
REQ-008 The port out_valid SHALL be an output, 1 bit wide, indicating that out_idx holds a granted channel.
REQ-009 The port out_idx SHALL be an output, W bits wide, carrying the granted channel index.
REQ-010 The port pending_any SHALL be an output, 1 bit wide, equal to the OR of the registered pending vector.

Function
REQ-011 The block SHALL keep a sticky N-bit pending register. Each request bit latches until it is granted.
REQ-012 The candidate vector SHALL be cand = pending | req; a request is grantable in the same cycle it arrives.
REQ-013 The output slot SHALL load when load = !out_valid || out_ready.
REQ-014 On load with cand != 0, the block SHALL register out_valid = 1 and out_idx = the selected index, and clear that bit in pending.
REQ-015 On load with cand == 0, the block SHALL register out_valid = 0 and leave out_idx unchanged.
REQ-016 While out_valid && !out_ready, out_idx, out_valid and the round-robin pointer SHALL hold; req still ORs into pending.
REQ-017 The pending update SHALL be pending_next = cand & ~grant_onehot when a grant occurs, and pending_next = cand otherwise.
REQ-018 A req bit equal to the index granted in the same cycle SHALL be consumed by that grant and SHALL NOT re-pend.
REQ-019 In mode 0, selection SHALL pick the highest set index of cand.
REQ-020 In mode 1, selection SHALL search downward from the pointer ptr, wrapping from index 0 to index N-1, and pick the first set bit.
REQ-021 After each mode-1 grant of index k, ptr SHALL become (k-1) mod N, with wrap from 0 to N-1.
REQ-022 ptr SHALL NOT change on mode-0 grants.
REQ-023 A change of mode SHALL take effect on the next load edge.
REQ-024 Latency SHALL be one cycle: a req asserted before edge t with the slot free appears on out_valid/out_idx after edge t.
REQ-025 Throughput SHALL be one grant per cycle while out_ready = 1.

Reset
REQ-026 With rst_n = 0 at a rising edge, the block SHALL set pending = 0, out_valid = 0, out_idx = 0, ptr = N-1 and pending_any = 0.
REQ-027 Requests present during reset SHALL be discarded; a reset mid-handshake drops the presented grant.
REQ-028 The first grant after reset in mode 1 SHALL therefore match fixed priority.

Structure
REQ-029 A shared package prior_pkg SHALL hold the mode encodings MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
REQ-030 The block SHALL contain one combinational sub-module, prior_sel, parametrised by N.
REQ-031 prior_sel SHALL take cand, ptr and mode and return sel_idx and sel_onehot.
REQ-032 prior_sel SHALL implement the rotate-by-pointer search as a double-width vector highest-set-bit search.
REQ-033 All state (pending, ptr, out_valid, out_idx) SHALL reside in prior_encoder_rr.

Verification
REQ-034 The bench SHALL cover, with N=8, mode=0, out_ready=1: req=8'b0100_0101 for one cycle -> out_idx 6, 2, 0 on three consecutive cycles, then out_valid=0.
REQ-035 The bench SHALL cover, with N=8, mode=1, req held at 8'hFF for 10 cycles -> out_idx 7, 6, 5, 4, 3, 2, 1, 0, 7, 6.
REQ-036 The bench SHALL cover backpressure: grant idx 5 presented, out_ready=0 for 4 cycles while req pulses bit 7 -> out_idx holds 5; then out_ready=1 -> next out_idx 7; pending_any=1 throughout the stall.
REQ-037 The bench SHALL cover same-cycle collision: pending bit 3 is granted while req[3]=1 in the same cycle -> a single grant of 3 and pending[3]=0 afterward.
REQ-038 The bench SHALL cover, with mode=1, ptr after granting 2 and pending = bits {1, 6} -> next grant 1, then 6.
REQ-039 The bench SHALL cover reset: rst_n=0 for one edge while out_valid=1 and pending=8'h0F -> all outputs 0 the next cycle, and no grants afterward without new req.
